// File: rtl/omicron_pkg.sv
// Shared Omicron pipeline types: scoreboard entry layout and the forwarding-select encoder.
package omicron_pkg;

   localparam int RA_MAX = 8;   // widest register address any configuration may use
   localparam int MV_MAX = 8;   // widest match vector any configuration may use
   localparam int FWD_RF = 0;   // operand select value meaning "read the register file"

   typedef struct packed {
      logic              valid;
      logic [RA_MAX-1:0] rd;
      logic              we;
      logic              is_load;
   } sb_entry_t;

   // Youngest (lowest index) match wins; entry k maps to select k+1.
   function automatic logic [3:0] fwd_sel_of(input logic [MV_MAX-1:0] mv);
      fwd_sel_of = 4'(FWD_RF);
      for (int k = MV_MAX-1; k >= 0; k--)
         if (mv[k]) fwd_sel_of = 4'(k + 1);
   endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-stage request and hazard-control response bundle between the decoder and the hazard unit.
interface pipe_hazard_unit_if #(
   parameter int REG_AW = 4,
   parameter int SEL_W  = 2
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs_a;
   logic              id_rs_a_used;
   logic [REG_AW-1:0] id_rs_b;
   logic              id_rs_b_used;
   logic [REG_AW-1:0] id_rd;
   logic              id_rd_we;
   logic              id_is_load;
   logic              br_taken;

   logic              stall;
   logic [SEL_W-1:0]  fwd_sel_a;
   logic [SEL_W-1:0]  fwd_sel_b;
   logic              flush;
   logic              pipe_busy;
   logic [15:0]       stall_cnt;

   modport master (
      output id_valid, id_rs_a, id_rs_a_used, id_rs_b, id_rs_b_used,
             id_rd, id_rd_we, id_is_load, br_taken,
      input  stall, fwd_sel_a, fwd_sel_b, flush, pipe_busy, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs_a, id_rs_a_used, id_rs_b, id_rs_b_used,
             id_rd, id_rd_we, id_is_load, br_taken,
      output stall, fwd_sel_a, fwd_sel_b, flush, pipe_busy, stall_cnt
   );
endinterface

// File: rtl/hazard_match.sv
// Per-source priority match of one ID operand against the checked scoreboard entries.
module hazard_match
   import omicron_pkg::*;
#(
   parameter int REG_AW   = 4,
   parameter int NCHK     = 2,
   parameter int ZERO_REG = 1
) (
   input  logic [REG_AW-1:0]   src_i,
   input  logic                used_i,
   input  sb_entry_t [NCHK-1:0] sb_i,
   output logic                hit_o,
   output logic [2:0]          hit_idx_o,
   output logic                hit_is_load_o
);

   logic [MV_MAX-1:0] mv;
   logic              src_zero;
   logic [3:0]        sel;

   assign src_zero = (ZERO_REG != 0) && (src_i == '0);

   generate
      for (genvar k = 0; k < MV_MAX; k++) begin : g_m
         if (k < NCHK) begin : g_chk
            assign mv[k] = used_i & sb_i[k].valid & sb_i[k].we & ~src_zero &
                           (sb_i[k].rd == RA_MAX'(src_i));
         end else begin : g_nc
            assign mv[k] = 1'b0;
         end
      end
   endgenerate

   assign sel       = fwd_sel_of(mv);
   assign hit_o     = (sel != 4'(FWD_RF));
   assign hit_idx_o = hit_o ? 3'(sel - 4'd1) : 3'd0;

   always_comb begin
      hit_is_load_o = 1'b0;
      for (int k = 0; k < NCHK; k++)
         if (hit_o && (hit_idx_o == 3'(k))) hit_is_load_o = sb_i[k].is_load;
   end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Omicron hazard/forwarding/flush controller: scoreboard of in-flight destinations after ID.
module pipe_hazard_unit
   import omicron_pkg::*;
#(
   parameter int REG_AW   = 4,
   parameter int STAGES   = 3,
   parameter int FWD_EN   = 1,
   parameter int ZERO_REG = 1,
   parameter int SEL_W    = 2
) (
   input  logic               clk,
   input  logic               rst,
   pipe_hazard_unit_if.slave  hz
);

   localparam int NCHK = STAGES - 1;

   sb_entry_t [STAGES-1:0] sb_q, sb_d;
   logic                   flush_q;
   logic [15:0]            stall_cnt_q, stall_cnt_d;

   logic       hit_a, hit_b, ld_a, ld_b;
   logic [2:0] idx_a, idx_b;
   logic       need_a, need_b, stall;
   logic [SEL_W-1:0] sel_a, sel_b;
   logic       load_id;

   hazard_match #(.REG_AW(REG_AW), .NCHK(NCHK), .ZERO_REG(ZERO_REG)) u_match_a (
      .src_i(hz.id_rs_a), .used_i(hz.id_rs_a_used), .sb_i(sb_q[NCHK-1:0]),
      .hit_o(hit_a), .hit_idx_o(idx_a), .hit_is_load_o(ld_a)
   );

   hazard_match #(.REG_AW(REG_AW), .NCHK(NCHK), .ZERO_REG(ZERO_REG)) u_match_b (
      .src_i(hz.id_rs_b), .used_i(hz.id_rs_b_used), .sb_i(sb_q[NCHK-1:0]),
      .hit_o(hit_b), .hit_idx_o(idx_b), .hit_is_load_o(ld_b)
   );

   always_comb begin
      need_a = 1'b0;
      need_b = 1'b0;
      sel_a  = SEL_W'(FWD_RF);
      sel_b  = SEL_W'(FWD_RF);
      if (FWD_EN != 0) begin
         // only a load still in EX cannot be forwarded yet
         need_a = hit_a && (idx_a == 3'd0) && ld_a;
         need_b = hit_b && (idx_b == 3'd0) && ld_b;
         if (hit_a) sel_a = SEL_W'(idx_a + 3'd1);
         if (hit_b) sel_b = SEL_W'(idx_b + 3'd1);
      end else begin
         need_a = hit_a;
         need_b = hit_b;
      end
      if (!hz.id_valid) begin
         sel_a = SEL_W'(FWD_RF);
         sel_b = SEL_W'(FWD_RF);
      end
   end

   assign stall   = hz.id_valid & (need_a | need_b) & ~hz.br_taken;
   assign load_id = hz.id_valid & ~stall & ~hz.br_taken & ~flush_q;

   always_comb begin
      sb_d = '0;
      if (load_id) begin
         sb_d[0].valid   = 1'b1;
         sb_d[0].rd      = RA_MAX'(hz.id_rd);
         sb_d[0].we      = hz.id_rd_we;
         sb_d[0].is_load = hz.id_is_load;
      end
      for (int k = 1; k < STAGES; k++) sb_d[k] = sb_q[k-1];
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_q        <= '0;
         flush_q     <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         sb_q        <= sb_d;
         flush_q     <= hz.br_taken;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      hz.pipe_busy = 1'b0;
      for (int k = 0; k < STAGES; k++) hz.pipe_busy = hz.pipe_busy | sb_q[k].valid;
   end

   assign hz.stall     = stall;
   assign hz.fwd_sel_a = sel_a;
   assign hz.fwd_sel_b = sel_b;
   assign hz.flush     = flush_q;
   assign hz.stall_cnt = stall_cnt_q;

   // the WB entry is only tracked for occupancy; its result is already in the register file
   logic unused_wb;
   assign unused_wb = ^{sb_q[STAGES-1].rd, sb_q[STAGES-1].we, sb_q[STAGES-1].is_load};

endmodule
